// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory arbiter.
//   ramstate_t  : handshake state reported by the RAM model
//   word_t      : 32-bit data/address word
//   arb_state_t : arbiter FSM states
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IREQ = 2'd1,
        DREQ = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between an instruction-fetch port and a data
// load/store port.
//   CLK, RST            : clock, synchronous active-high reset
//   iREN, iaddr         : fetch request and address
//   dREN, dWEN, daddr,
//   dstore              : data load/store request, address, store data
//   ihit, iload         : fetch completion pulse and fetched word
//   dhit, dload         : data completion pulse and loaded word
//   ramaddr, ramstore,
//   ramREN, ramWEN      : RAM request driven from the latched transaction
//   ramload, ramstate   : RAM read data and handshake state
//   merr                : sticky error flag, set when a transaction is
//                         aborted after MAX_RETRY consecutive ERROR cycles
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_RETRY = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output logic      dhit,
    output word_t     iload,
    output word_t     dload,
    output word_t     ramaddr,
    output word_t     ramstore,
    output logic      ramREN,
    output logic      ramWEN,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      merr
);

    localparam int RETRY_W = $clog2(MAX_RETRY) + 1;
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    arb_state_t         state_reg, state_next;
    logic               last_data_reg, last_data_next;  // last completed grant was data
    word_t              addr_reg, addr_next;
    word_t              store_reg, store_next;
    logic               write_reg, write_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic               merr_reg, merr_next;

    logic dreq;
    assign dreq = dREN | dWEN;
    assign merr = merr_reg;

    always_comb begin
        state_next     = state_reg;
        last_data_next = last_data_reg;
        addr_next      = addr_reg;
        store_next     = store_reg;
        write_next     = write_reg;
        retry_next     = retry_reg;
        merr_next      = merr_reg;
        ihit           = 1'b0;
        dhit           = 1'b0;
        iload          = '0;
        dload          = '0;
        ramaddr        = '0;
        ramstore       = '0;
        ramREN         = 1'b0;
        ramWEN         = 1'b0;

        case (state_reg)
            IDLE: begin
                // Data normally wins; yield to a waiting fetch if data
                // completed last, so neither side can starve the other.
                if (dreq && !(iREN && last_data_reg)) begin
                    state_next = DREQ;
                    addr_next  = daddr;
                    store_next = dstore;
                    write_next = dWEN;   // load+store together is a store
                    retry_next = '0;
                end else if (iREN) begin
                    state_next = IREQ;
                    addr_next  = iaddr;
                    store_next = '0;
                    write_next = 1'b0;
                    retry_next = '0;
                end
            end

            IREQ, DREQ: begin
                ramaddr  = addr_reg;
                ramstore = store_reg;
                ramREN   = ~write_reg;
                ramWEN   = write_reg;
                case (ramstate)
                    ACCESS: begin
                        state_next = IDLE;
                        retry_next = '0;
                        if (state_reg == IREQ) begin
                            ihit           = 1'b1;
                            iload          = ramload;
                            last_data_next = 1'b0;
                        end else begin
                            dhit           = 1'b1;
                            dload          = write_reg ? '0 : ramload;
                            last_data_next = 1'b1;
                        end
                    end
                    ERROR: begin
                        if (retry_reg == RETRY_LAST) begin
                            state_next = IDLE;
                            retry_next = '0;
                            merr_next  = 1'b1;
                        end else begin
                            retry_next = retry_reg + 1'b1;
                        end
                    end
                    default: begin
                        // FREE/BUSY: keep waiting with strobes held
                    end
                endcase
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            last_data_reg <= 1'b0;
            addr_reg      <= '0;
            store_reg     <= '0;
            write_reg     <= 1'b0;
            retry_reg     <= '0;
            merr_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_data_reg <= last_data_next;
            addr_reg      <= addr_next;
            store_reg     <= store_next;
            write_reg     <= write_next;
            retry_reg     <= retry_next;
            merr_reg      <= merr_next;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      ihit, dhit, ramREN, ramWEN, merr;
    word_t     iload, dload, ramaddr, ramstore;

    int vectors = 0;
    int miscompares = 0;

    memory_arbiter #(.MAX_RETRY(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramload(ramload), .ramstate(ramstate), .merr(merr)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
    endtask

    // flags = {ihit, dhit, ramREN, ramWEN}
    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        iREN = 1'b1; iaddr = 32'h1234;
        tick();
        tick();
        RST = 1'b0;
        iREN = 1'b0;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN, merr} !== 5'b0 || ramaddr !== 32'h0 || iload !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: flags=%b merr=%b ramaddr=%h iload=%h, required all 0",
                     {ihit, dhit, ramREN, ramWEN}, merr, ramaddr, iload);
        end
        tick();
    endtask

    task automatic test_lone_fetch();
        iREN = 1'b1; iaddr = 32'h40;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
            miscompares++;
            $display("FAIL fetch_idle: flags=%b required 0000", {ihit, dhit, ramREN, ramWEN});
        end
        tick();
        // requester drops and changes address; transaction must continue unchanged
        iREN = 1'b0; iaddr = 32'h999; ramstate = BUSY;
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++;
            if ({ihit, dhit, ramREN, ramWEN} !== 4'b0010 || ramaddr !== 32'h40) begin
                miscompares++;
                $display("FAIL fetch_busy%0d: flags=%b ramaddr=%h required 0010 00000040",
                         k, {ihit, dhit, ramREN, ramWEN}, ramaddr);
            end
            tick();
        end
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b1010 || iload !== 32'hDEADBEEF || dload !== 32'h0) begin
            miscompares++;
            $display("FAIL fetch_access: flags=%b iload=%h dload=%h required 1010 deadbeef 0",
                     {ihit, dhit, ramREN, ramWEN}, iload, dload);
        end
        tick();
        ramstate = FREE;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000 || iload !== 32'h0) begin
            miscompares++;
            $display("FAIL fetch_after: flags=%b iload=%h required 0000 0",
                     {ihit, dhit, ramREN, ramWEN}, iload);
        end
    endtask

    task automatic test_store_then_fetch();
        iREN = 1'b1; iaddr = 32'h100;
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        tick();
        dWEN = 1'b0; daddr = 32'hFF; dstore = 32'hBAD;
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0101 || ramaddr !== 32'h80 ||
            ramstore !== 32'h1234 || dload !== 32'h0) begin
            miscompares++;
            $display("FAIL store_first: flags=%b ramaddr=%h ramstore=%h dload=%h required 0101 80 1234 0",
                     {ihit, dhit, ramREN, ramWEN}, ramaddr, ramstore, dload);
        end
        tick();
        ramstate = FREE;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
            miscompares++;
            $display("FAIL store_gap: flags=%b required 0000", {ihit, dhit, ramREN, ramWEN});
        end
        tick();
        ramstate = ACCESS; ramload = 32'h55;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b1010 || ramaddr !== 32'h100 || iload !== 32'h55) begin
            miscompares++;
            $display("FAIL fetch_second: flags=%b ramaddr=%h iload=%h required 1010 100 55",
                     {ihit, dhit, ramREN, ramWEN}, ramaddr, iload);
        end
        iREN = 1'b0;
        tick();
        ramstate = FREE;
    endtask

    task automatic test_round_robin();
        // 0 = idle gap, 1 = data hit, 2 = fetch hit
        int exp_kind [10] = '{0, 1, 0, 2, 0, 1, 0, 2, 0, 1};
        logic [1:0] exp_hits;
        dREN = 1'b1; daddr = 32'h200;
        iREN = 1'b1; iaddr = 32'h300;
        ramstate = ACCESS; ramload = 32'hA5;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_hits = (exp_kind[k] == 2) ? 2'b10 : (exp_kind[k] == 1) ? 2'b01 : 2'b00;
            vectors++;
            if ({ihit, dhit} !== exp_hits ||
                (exp_kind[k] == 1 && (ramaddr !== 32'h200 || dload !== 32'hA5)) ||
                (exp_kind[k] == 2 && (ramaddr !== 32'h300 || iload !== 32'hA5))) begin
                miscompares++;
                $display("FAIL round_robin%0d: ihit,dhit=%b ramaddr=%h required %b",
                         k, {ihit, dhit}, ramaddr, exp_hits);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_retry_ok();
        dREN = 1'b1; daddr = 32'h10;
        tick();
        dREN = 1'b0; ramstate = ERROR;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if ({ihit, dhit, ramREN, ramWEN} !== 4'b0010 || ramaddr !== 32'h10) begin
                miscompares++;
                $display("FAIL retry_hold%0d: flags=%b ramaddr=%h required 0010 10",
                         k, {ihit, dhit, ramREN, ramWEN}, ramaddr);
            end
            tick();
        end
        ramstate = ACCESS; ramload = 32'h77;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0110 || dload !== 32'h77 || merr !== 1'b0) begin
            miscompares++;
            $display("FAIL retry_ok: flags=%b dload=%h merr=%b required 0110 77 0",
                     {ihit, dhit, ramREN, ramWEN}, dload, merr);
        end
        tick();
        ramstate = FREE;
    endtask

    task automatic test_retry_abort();
        dWEN = 1'b1; daddr = 32'h20; dstore = 32'h99;
        tick();
        dWEN = 1'b0; ramstate = ERROR;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if ({ihit, dhit, ramREN, ramWEN} !== 4'b0001 || merr !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_err%0d: flags=%b merr=%b required 0001 0",
                         k, {ihit, dhit, ramREN, ramWEN}, merr);
            end
            tick();
        end
        ramstate = FREE;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000 || merr !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_idle: flags=%b merr=%b required 0000 1",
                     {ihit, dhit, ramREN, ramWEN}, merr);
        end
        // merr stays set through a later successful transaction
        iREN = 1'b1; iaddr = 32'h8;
        tick();
        iREN = 1'b0; ramstate = ACCESS; ramload = 32'h3;
        #1;
        vectors++;
        if (ihit !== 1'b1 || iload !== 32'h3 || merr !== 1'b1) begin
            miscompares++;
            $display("FAIL merr_sticky: ihit=%b iload=%h merr=%b required 1 3 1", ihit, iload, merr);
        end
        tick();
        ramstate = FREE;
    endtask

    task automatic test_reset_mid();
        dREN = 1'b1; daddr = 32'h30;
        tick();
        dREN = 1'b0; ramstate = BUSY;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0010) begin
            miscompares++;
            $display("FAIL midreset_pre: flags=%b required 0010", {ihit, dhit, ramREN, ramWEN});
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000 || merr !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_post: flags=%b merr=%b required 0000 0",
                     {ihit, dhit, ramREN, ramWEN}, merr);
        end
        iREN = 1'b1; iaddr = 32'h44; ramstate = ACCESS; ramload = 32'h4444;
        tick();
        iREN = 1'b0;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b1010 || ramaddr !== 32'h44 || iload !== 32'h4444) begin
            miscompares++;
            $display("FAIL midreset_fetch: flags=%b ramaddr=%h iload=%h required 1010 44 4444",
                     {ihit, dhit, ramREN, ramWEN}, ramaddr, iload);
        end
        tick();
        ramstate = FREE;
    endtask

    task automatic test_read_write_both();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h60; dstore = 32'hCAFE;
        ramload = 32'hFFFF_FFFF;
        tick();
        dREN = 1'b0; dWEN = 1'b0; ramstate = ACCESS;
        #1;
        vectors++;
        if ({ihit, dhit, ramREN, ramWEN} !== 4'b0101 || dload !== 32'h0 ||
            ramstore !== 32'hCAFE || ramaddr !== 32'h60) begin
            miscompares++;
            $display("FAIL rw_both: flags=%b dload=%h ramstore=%h ramaddr=%h required 0101 0 cafe 60",
                     {ihit, dhit, ramREN, ramWEN}, dload, ramstore, ramaddr);
        end
        tick();
        ramstate = FREE;
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        tick();
        test_store_then_fetch();
        test_round_robin();
        test_retry_ok();
        test_retry_abort();
        test_reset_mid();
        test_read_write_both();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: CLK in 1, RST in 1 (active-high, synchronous); all state updates occur on CLK rising edge.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
 CLK  in  1  system clock
 RST  in  1  synchronous active-high reset
 iREN  in  1  instruction fetch request
 iaddr  in  32  fetch address
 dREN  in  1  data load request
 dWEN  in  1  data store request
 daddr  in  32  data address
 dstore  in  32  store data
 ihit  out  1  fetch complete, one-cycle pulse
 dhit  out  1  data access complete, one-cycle pulse
 iload  out  32  fetched word
 dload  out  32  loaded word
 ramaddr  out  32  RAM address
 ramstore  out  32  RAM write data
 ramREN  out  1  RAM read strobe
 ramWEN  out  1  RAM write strobe
 ramload  in  32  RAM read data
 ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
 merr  out  1  sticky memory-error flag
REQ-003 SHALL use parameter MAX_RETRY, default 4, meaning the number of consecutive ERROR cycles tolerated before abort.

Function
REQ-004 SHALL implement FSM states IDLE, IREQ, DREQ.
REQ-005 In IDLE, the next state SHALL be DREQ if dREN|dWEN, else IREQ if iREN, else IDLE.
REQ-006 Fairness: when dREN|dWEN and iREN are both high in IDLE and the last completed grant was data, the next state SHALL be IREQ.
REQ-007 On leaving IDLE, the block SHALL latch the address, store data and operation; a later requester change SHALL not alter the transaction in flight.
REQ-008 dREN and dWEN both high SHALL be treated as a write.
REQ-009 In IREQ/DREQ, ramaddr, ramstore and ramREN/ramWEN SHALL be driven from latched values; in IDLE all four SHALL be 0.
REQ-010 In IREQ/DREQ with ramstate==ACCESS, the matching hit SHALL assert combinationally that cycle, iload/dload SHALL equal ramload (0 for writes), and the FSM SHALL go to IDLE.
REQ-011 ihit/dhit SHALL be high for exactly one cycle per transaction and never simultaneously; iload/dload SHALL be 0 whenever their hit is low.
REQ-012 Latency: a request accepted at cycle N SHALL drive its strobe at N+1; hit at the first cycle ≥N+1 with ACCESS; back-to-back grants SHALL have one IDLE cycle between them.
REQ-013 ramstate FREE or BUSY SHALL hold state and strobes.
REQ-014 ramstate ERROR SHALL increment a retry counter (width clog2(MAX_RETRY)+1) and hold the request; ACCESS or a new grant SHALL clear it.
REQ-015 On the MAX_RETRY-th consecutive ERROR, the transaction SHALL be aborted to IDLE with no hit, and merr SHALL set and stay high until reset.
REQ-016 A requester deasserting its request mid-transaction SHALL not abort it; the hit pulse is still produced.

Reset
REQ-017 While RST is high at an edge: state IDLE, last-grant=instruction, retry=0, merr=0; from the next cycle all outputs SHALL be 0.
REQ-018 Reset mid-transaction SHALL abort it with no hit; strobes SHALL be low the cycle after the reset edge.

Structure
REQ-019 ramstate_t, word_t and arb_state_t SHALL live in cpu_types_pkg; MAX_RETRY is a module parameter.
REQ-020 SHALL be a single module with no sub-modules; FSM next-state and output logic in always_comb, registers in one always_ff.

Verification
REQ-021 Lone fetch iaddr=0x40, RAM returns BUSY,BUSY,ACCESS with ramload=0xDEADBEEF -> ihit one cycle later than ACCESS onset? No: ihit in the ACCESS cycle, iload=0xDEADBEEF, ramREN low the next cycle.
REQ-022 iREN and dWEN (daddr=0x80, dstore=0x1234) raised together from IDLE -> store first (ramWEN, ramaddr=0x80), dhit, then fetch granted and ihit.
REQ-023 dREN held through three loads with iREN high -> grant order D, I, D, I; neither requester is starved.
REQ-024 ramstate ERROR for 3 cycles then ACCESS -> normal dhit, merr=0; ERROR for 4 cycles -> no hit, IDLE, merr=1 until RST.
REQ-025 RST asserted during DREQ while BUSY -> no dhit, strobes 0 the cycle after the edge, merr=0, and the next iREN is granted normally.
REQ-026 dREN and dWEN both high -> ramWEN=1, ramREN=0, dload=0 on dhit.
